// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control path.
package calc_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [2:0] RES_HOLD  = 3'b000;
  localparam logic [2:0] RES_LOAD  = 3'b011;
  localparam logic [2:0] RES_CLEAR = 3'b100;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_DIGIT = 3'd1,
    EV_OP    = 3'd2,
    EV_EQ    = 3'd3,
    EV_CLR   = 3'd4
  } key_event_t;

  // Registered control word driven to the datapath.
  typedef struct packed {
    logic       reg_a_en;
    logic       reg_b_en;
    logic       reg_clr;
    logic       res_to_a;
    logic [1:0] alu_op;
    logic       alu_start;
    logic [2:0] res_sel;
    logic       busy;
    logic       error;
  } ctrl_t;

  // Only the highest-priority keypress of a cycle survives.
  function automatic key_event_t pick_event(input logic clr, input logic eq,
                                            input logic op, input logic digit);
    if (clr)        return EV_CLR;
    else if (eq)    return EV_EQ;
    else if (op)    return EV_OP;
    else if (digit) return EV_DIGIT;
    else            return EV_NONE;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad events, datapath flags and datapath controls of the calculator sequencer.
interface calc_sequencer_if;
  logic       digit_valid;
  logic       op_valid;
  logic [1:0] op_code;
  logic       eq_valid;
  logic       clr_valid;
  logic       b_is_zero;
  logic       alu_done;

  logic       reg_a_en;
  logic       reg_b_en;
  logic       reg_clr;
  logic       res_to_a;
  logic [1:0] alu_op;
  logic       alu_start;
  logic [2:0] res_sel;
  logic       busy;
  logic       error;

  modport master (
    output digit_valid, op_valid, op_code, eq_valid, clr_valid, b_is_zero, alu_done,
    input  reg_a_en, reg_b_en, reg_clr, res_to_a, alu_op, alu_start, res_sel, busy, error
  );

  modport slave (
    input  digit_valid, op_valid, op_code, eq_valid, clr_valid, b_is_zero, alu_done,
    output reg_a_en, reg_b_en, reg_clr, res_to_a, alu_op, alu_start, res_sel, busy, error
  );
endinterface

// File: rtl/calc_exec_timer.sv
// Cycle counter for the ALU wait; expired marks the last cycle the ALU may still answer.
module calc_exec_timer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CW'(TIMEOUT_CYC))) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // count_reg holds the number of wait cycles already elapsed before this one.
  assign expired = enable && (count_reg == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM for the 8-bit calculator datapath.
// Define CALC_CHAIN_EN to let an operator pressed on a shown result reuse it as operand A.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input logic             clock,
  input logic             reset_n,
  calc_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  ctrl_t            ctrl_reg, ctrl_next;
  key_event_t       key_ev;
  logic             timer_expired;
  logic             in_exec;

  assign in_exec = (state_reg == S_EXEC);

  calc_exec_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!in_exec),
    .enable  (in_exec),
    .expired (timer_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_A;
      count_reg <= '0;
      ctrl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ctrl_reg  <= ctrl_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    count_next         = count_reg;
    ctrl_next          = '0;
    ctrl_next.alu_op   = ctrl_reg.alu_op;
    ctrl_next.res_sel  = RES_HOLD;
    key_ev             = pick_event(bus.clr_valid, bus.eq_valid, bus.op_valid, bus.digit_valid);

    if (key_ev == EV_CLR) begin
      ctrl_next.reg_clr = 1'b1;
      ctrl_next.res_sel = RES_CLEAR;
      state_next        = S_A;
      count_next        = '0;
    end else begin
      case (state_reg)
        S_A: begin
          if (key_ev == EV_DIGIT && count_reg < CNT_W'(MAX_DIGITS)) begin
            ctrl_next.reg_a_en = 1'b1;
            count_next         = count_reg + CNT_W'(1);
          end else if (key_ev == EV_OP) begin
            ctrl_next.alu_op = bus.op_code;
            count_next       = '0;
            state_next       = S_OP;
          end
        end

        S_OP: begin
          if (key_ev == EV_DIGIT) begin
            ctrl_next.reg_b_en = 1'b1;
            count_next         = CNT_W'(1);
            state_next         = S_B;
          end else if (key_ev == EV_OP) begin
            ctrl_next.alu_op = bus.op_code;
          end
        end

        S_B: begin
          if (key_ev == EV_DIGIT && count_reg < CNT_W'(MAX_DIGITS)) begin
            ctrl_next.reg_b_en = 1'b1;
            count_next         = count_reg + CNT_W'(1);
          end else if (key_ev == EV_EQ) begin
            // Divide by zero is trapped before the ALU ever starts.
            if (ctrl_reg.alu_op == OP_DIV && bus.b_is_zero) begin
              ctrl_next.res_sel = RES_CLEAR;
              state_next        = S_ERR;
            end else begin
              ctrl_next.alu_start = 1'b1;
              state_next          = S_EXEC;
            end
          end
        end

        S_EXEC: begin
          // A done landing on the expiry cycle still counts as success.
          if (bus.alu_done) begin
            ctrl_next.res_sel = RES_LOAD;
            state_next        = S_SHOW;
          end else if (timer_expired) begin
            ctrl_next.res_sel = RES_CLEAR;
            state_next        = S_ERR;
          end
        end

        S_SHOW: begin
          if (key_ev == EV_DIGIT) begin
            ctrl_next.reg_clr  = 1'b1;
            ctrl_next.reg_a_en = 1'b1;
            count_next         = CNT_W'(1);
            state_next         = S_A;
          end
`ifdef CALC_CHAIN_EN
          else if (key_ev == EV_OP) begin
            ctrl_next.res_to_a = 1'b1;
            ctrl_next.alu_op   = bus.op_code;
            count_next         = '0;
            state_next         = S_OP;
          end
`endif
        end

        S_ERR: begin
          state_next = S_ERR;
        end

        default: begin
          state_next = S_A;
          count_next = '0;
        end
      endcase
    end

    ctrl_next.busy  = (state_next == S_EXEC);
    ctrl_next.error = (state_next == S_ERR);
  end

  assign bus.reg_a_en  = ctrl_reg.reg_a_en;
  assign bus.reg_b_en  = ctrl_reg.reg_b_en;
  assign bus.reg_clr   = ctrl_reg.reg_clr;
  assign bus.res_to_a  = ctrl_reg.res_to_a;
  assign bus.alu_op    = ctrl_reg.alu_op;
  assign bus.alu_start = ctrl_reg.alu_start;
  assign bus.res_sel   = ctrl_reg.res_sel;
  assign bus.busy      = ctrl_reg.busy;
  assign bus.error     = ctrl_reg.error;

endmodule
